lin_conv_stream: RTL
====================

# lin_conv_stream

Streaming, parametrised linear-convolution engine: y[n] = Σ h[k]·x[n−k] for a TAPS-coefficient kernel and an input sequence of any length L ≥ 1. It generalises the team's fixed 4×4 block-convolution datapath into a pipelined, handshaked unit. It produces all L+TAPS−1 full-precision outputs, including the tail, without external overlap-add. It sits between a sample source and a result sink on valid/ready streams; coefficients are loaded serially and retained across sequences.

## Interface
- DW, 4: sample and coefficient width.
- TAPS, 4: kernel length, ≥ 2.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and result.
- ACCW (localparam) = 2·DW + $clog2(TAPS): output width; full precision, never overflows.

- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- coef_valid  in  1  coefficient beat offered.
- coef_data  in  DW  coefficient; first beat is h[0].
- coef_ready  out  1  coefficient beat accepted when coef_valid && coef_ready.
- s_valid  in  1  input sample offered.
- s_data  in  DW  sample x[n].
- s_last  in  1  marks the final sample of a sequence.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- m_valid  out  1  output sample held.
- m_data  out  ACCW  y[n].
- m_last  out  1  marks y[L+TAPS−2].
- m_ready  in  1  sink accepts when m_valid && m_ready.

## Operation
- States: COEF, RUN, FLUSH.
- Reset: state = COEF; all h[k] = 0; sample delay line = 0; coef_cnt = 0; seq_active = 0.
- Reset output values: m_valid = 0, m_data = 0, m_last = 0, s_ready = 0, coef_ready = 1.
- COEF:
  - coef_ready = 1, s_ready = 0.
  - Each accepted beat writes h[coef_cnt] and increments coef_cnt.
  - After beat TAPS−1: go to RUN, clear coef_cnt.
- RUN:
  - s_ready = (!m_valid || m_ready) && !(coef_valid && coef_ready).
  - Accepted sample shifts into delay line d[0]; d[k] ← d[k−1].
  - Output register loads Σ h[k]·d'[k], computed over the post-shift line.
  - seq_active is set on the first sample and cleared after the final flush output.
  - Accepted sample with s_last = 1: go to FLUSH, flush_cnt = TAPS−1.
- FLUSH:
  - s_ready = 0, coef_ready = 0.
  - Whenever the output register is free (!m_valid || m_ready), shift a 0 into the line, load one output, and decrement flush_cnt.
  - The output with flush_cnt reaching 0 carries m_last = 1.
  - Then clear the delay line, clear seq_active, and return to RUN. Coefficients are kept.
- Coefficient reload:
  - In RUN, coef_ready = 1 only when !seq_active && !m_valid.
  - An accepted beat there is h[0] and moves the state to COEF with coef_cnt = 1.
  - Simultaneous coef_valid and s_valid in that condition: the coefficient wins, and s_ready = 0 for that cycle.
- Arithmetic:
  - SIGNED = 0: zero-extend products.
  - SIGNED = 1: sign-extend operands to ACCW before multiply and accumulate.
- Sequences of L = 1 are legal: s_last on the first sample produces TAPS outputs.

## Timing
- Latency: output is valid the cycle after the sample is accepted.
- Throughput: 1 sample/cycle with m_ready held high.
- FLUSH adds TAPS−1 cycles (minimum) before the next sequence's first sample is accepted.
- Single output register: m_data and m_last hold stable while m_valid && !m_ready.
- Backpressure propagates to s_ready in the same cycle (combinational from m_ready).
- Reset asserted in any state, mid-sequence or mid-flush: next cycle all outputs take their reset values; the pending output is discarded; coefficients are lost.

## Test plan
- Basic convolution, unsigned defaults:
  - Load h = 1,2,3,4; send x = 1,1 (s_last on the second).
  - Required: m_data = 1,3,5,7,4, with m_last only on the 5th output.
- Single-sample sequence, same h:
  - Send x = 5 with s_last.
  - Required: 5,10,15,20, with m_last on the 4th; then a second sequence 1,1 reproduces 1,3,5,7,4, showing no residue in the delay line.
- Maximum magnitude:
  - h = 15×4; x = 15×4.
  - Required: 225,450,675,900,675,450,225; 900 fits in 10 bits without wrap.
- Signed mode, SIGNED = 1:
  - h = −1,2,0,0; x = 3,−2.
  - Required: 10'h3FD (−3), 8, 10'h3FC (−4), 0, 0.
- Backpressure:
  - Basic stimulus with m_ready toggling 1,0,0,1,…
  - Required: identical output sequence, no drops or duplicates; m_data stable while stalled; s_ready = 0 whenever m_valid && !m_ready.
- Control corner cases:
  - coef_valid asserted mid-sequence: must be ignored (coef_ready = 0).
  - rst asserted during FLUSH: m_valid = 0 next cycle; state is COEF; s_ready = 0 until TAPS new coefficients are loaded.

Source files
------------

// File: rtl/lin_conv_stream_if.sv
// Stream bundle for lin_conv_stream: coefficient load port, sample input and result output.
// The master side is the source/sink environment; the slave side is the convolution engine.
interface lin_conv_stream_if #(
   parameter int DW   = 4,
   parameter int TAPS = 4
);
   localparam int ACCW = 2 * DW + $clog2(TAPS);

   logic            coef_valid;
   logic [DW-1:0]   coef_data;
   logic            coef_ready;
   logic            s_valid;
   logic [DW-1:0]   s_data;
   logic            s_last;
   logic            s_ready;
   logic            m_valid;
   logic [ACCW-1:0] m_data;
   logic            m_last;
   logic            m_ready;

   modport master (
      output coef_valid, coef_data, s_valid, s_data, s_last, m_ready,
      input  coef_ready, s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  coef_valid, coef_data, s_valid, s_data, s_last, m_ready,
      output coef_ready, s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/lin_conv_stream.sv
// Streaming linear convolution y[n] = sum h[k]*x[n-k] with serial coefficient load
// and automatic zero-flush of the TAPS-1 tail outputs after each sequence.
module lin_conv_stream #(
   parameter int DW     = 4,
   parameter int TAPS   = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   lin_conv_stream_if.slave bus
);
   localparam int ACCW = 2 * DW + $clog2(TAPS);
   localparam int CW   = $clog2(TAPS);
   localparam logic [CW-1:0] LAST_IDX = CW'(TAPS - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   typedef enum logic [1:0] {COEF, RUN, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   h_q    [TAPS];
   logic [DW-1:0]   h_d    [TAPS];
   logic [DW-1:0]   hist_q [TAPS-1];
   logic [DW-1:0]   hist_d [TAPS-1];
   logic [CW-1:0]   coef_cnt_q, coef_cnt_d;
   logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
   logic            seq_active_q, seq_active_d;
   logic            m_valid_q, m_valid_d;
   logic [ACCW-1:0] m_data_q, m_data_d;
   logic            m_last_q, m_last_d;

   logic                   out_free, coef_rdy, s_rdy;
   logic                   coef_acc, s_acc, flush_step, shift;
   logic [DW-1:0]          tap_p0 [TAPS];
   logic signed [ACCW-1:0] acc_p0;

   function automatic logic signed [ACCW-1:0] ext(input logic [DW-1:0] v);
      return {{(ACCW-DW){SIGNED & v[DW-1]}}, v};
   endfunction

   always_comb begin
      out_free = !m_valid_q || bus.m_ready;
      coef_rdy = 1'b0;
      s_rdy    = 1'b0;
      case (state_q)
         COEF: coef_rdy = 1'b1;
         RUN: begin
            coef_rdy = !seq_active_q && !m_valid_q;
            s_rdy    = out_free && !(bus.coef_valid && coef_rdy);
         end
         default: ;
      endcase
      coef_acc   = bus.coef_valid && coef_rdy;
      s_acc      = bus.s_valid && s_rdy;
      flush_step = (state_q == FLUSH) && out_free;
      shift      = s_acc || flush_step;
   end

   // stage p0: post-shift delay line and multiply-accumulate
   always_comb begin
      tap_p0[0] = s_acc ? bus.s_data : '0;
      for (int k = 1; k < TAPS; k++) tap_p0[k] = hist_q[k-1];
      acc_p0 = '0;
      for (int k = 0; k < TAPS; k++) acc_p0 = acc_p0 + ext(h_q[k]) * ext(tap_p0[k]);
   end

   always_comb begin
      state_d      = state_q;
      h_d          = h_q;
      hist_d       = hist_q;
      coef_cnt_d   = coef_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      seq_active_d = seq_active_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_last_d     = m_last_q;

      if (bus.m_ready) m_valid_d = 1'b0;
      if (shift) begin
         m_valid_d = 1'b1;
         m_data_d  = acc_p0;
         m_last_d  = flush_step && (flush_cnt_q == ONE);
         for (int k = 0; k < TAPS - 1; k++) hist_d[k] = tap_p0[k];
      end

      case (state_q)
         COEF: begin
            if (coef_acc) begin
               h_d[coef_cnt_q] = bus.coef_data;
               if (coef_cnt_q == LAST_IDX) begin
                  coef_cnt_d = '0;
                  state_d    = RUN;
               end else begin
                  coef_cnt_d = coef_cnt_q + ONE;
               end
            end
         end
         RUN: begin
            if (coef_acc) begin
               h_d[0]     = bus.coef_data;
               coef_cnt_d = ONE;
               state_d    = COEF;
            end else if (s_acc) begin
               seq_active_d = 1'b1;
               if (bus.s_last) begin
                  flush_cnt_d = LAST_IDX;
                  state_d     = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (flush_step) begin
               flush_cnt_d = flush_cnt_q - ONE;
               // Final tail output: leave no residue for the next sequence.
               if (flush_cnt_q == ONE) begin
                  for (int k = 0; k < TAPS - 1; k++) hist_d[k] = '0;
                  seq_active_d = 1'b0;
                  state_d      = RUN;
               end
            end
         end
         default: state_d = COEF;
      endcase
   end

   // stage p1: output register and control state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= COEF;
         for (int k = 0; k < TAPS; k++) h_q[k] <= '0;
         for (int k = 0; k < TAPS - 1; k++) hist_q[k] <= '0;
         coef_cnt_q   <= '0;
         flush_cnt_q  <= '0;
         seq_active_q <= 1'b0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_last_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         h_q          <= h_d;
         hist_q       <= hist_d;
         coef_cnt_q   <= coef_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         seq_active_q <= seq_active_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_last_q     <= m_last_d;
      end
   end

   assign bus.coef_ready = coef_rdy;
   assign bus.s_ready    = s_rdy;
   assign bus.m_valid    = m_valid_q;
   assign bus.m_data     = m_data_q;
   assign bus.m_last     = m_last_q;
endmodule
